// File: rtl/conv_output_collector.sv
// Packs Tm serial output features into one pixel word and writes the words through a 2-entry FIFO.
// Optional macro RELU_EN: negative features are clamped to zero before packing.
module conv_output_collector #(
  parameter int Tm            = 8,
  parameter int FEATURE_WIDTH = 16,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_enable,
  input  logic [15:0]                   cfg_pixel_count,
  input  logic [ADDR_WIDTH-1:0]         cfg_base_addr,
  input  logic                          feat_valid,
  input  logic [FEATURE_WIDTH-1:0]      feat_data,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [Tm*FEATURE_WIDTH-1:0]   wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  localparam int LW = (Tm > 1) ? $clog2(Tm) : 1;
  localparam int WW = Tm * FEATURE_WIDTH;
  localparam logic [LW-1:0] LANE_LAST = LW'(Tm - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             pixel_count_q;
  logic [ADDR_WIDTH-1:0]   base_addr_q;
  logic [LW-1:0]           lane_cnt_q;
  logic [WW-1:0]           pack_q;
  logic [15:0]             word_idx_q;
  logic [15:0]             words_written_q;
  logic [WW-1:0]           fifo_data_q [2];
  logic [ADDR_WIDTH-1:0]   fifo_addr_q [2];
  logic                    rd_ptr_q, wr_ptr_q;
  logic [1:0]              count_q;
  logic                    overflow_q;

  logic [FEATURE_WIDTH-1:0] feat_val;
  logic [WW-1:0]            packed_word;
  logic [ADDR_WIDTH-1:0]    push_addr;
  logic                     accept, push, pop, full, push_ok;

`ifdef RELU_EN
  assign feat_val = feat_data[FEATURE_WIDTH-1] ? '0 : feat_data;
`else
  assign feat_val = feat_data;
`endif

  // Beats past the configured word count are dropped by comparing against
  // the push index, which also advances on overflowed words.
  assign accept  = (state_q == S_COLLECT) && feat_valid && (word_idx_q != pixel_count_q);
  assign push    = accept && (lane_cnt_q == LANE_LAST);
  assign pop     = (count_q != 2'd0) && wr_ready;
  assign full    = (count_q == 2'd2);
  assign push_ok = push && (!full || pop);
  assign push_addr = base_addr_q + ADDR_WIDTH'(word_idx_q);

  always_comb begin
    packed_word = pack_q;
    packed_word[int'(lane_cnt_q)*FEATURE_WIDTH +: FEATURE_WIDTH] = feat_val;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = S_IDLE;
      // Look ahead at this cycle's handshake so done follows the last write directly.
      S_COLLECT: if ((words_written_q + 16'(pop)) == pixel_count_q) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (cfg_enable) state_d = S_COLLECT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_count_q   <= '0;
      base_addr_q     <= '0;
      lane_cnt_q      <= '0;
      pack_q          <= '0;
      word_idx_q      <= '0;
      words_written_q <= '0;
      overflow_q      <= 1'b0;
    end else if (cfg_enable) begin
      pixel_count_q   <= cfg_pixel_count;
      base_addr_q     <= cfg_base_addr;
      lane_cnt_q      <= '0;
      pack_q          <= '0;
      word_idx_q      <= '0;
      words_written_q <= '0;
      overflow_q      <= 1'b0;
    end else begin
      if (accept) begin
        pack_q     <= packed_word;
        lane_cnt_q <= (lane_cnt_q == LANE_LAST) ? '0 : lane_cnt_q + 1'b1;
      end
      if (push)            word_idx_q      <= word_idx_q + 16'd1;
      if (push && !push_ok) overflow_q     <= 1'b1;
      if (pop)             words_written_q <= words_written_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (cfg_enable) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        fifo_data_q[wr_ptr_q] <= packed_word;
        fifo_addr_q[wr_ptr_q] <= push_addr;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push_ok) - 2'(pop);
    end
  end

  assign wr_valid = (count_q != 2'd0);
  assign wr_data  = fifo_data_q[rd_ptr_q];
  assign wr_addr  = fifo_addr_q[rd_ptr_q];
  assign busy     = (state_q == S_COLLECT);
  assign done     = (state_q == S_DONE);
  assign overflow = overflow_q;

endmodule
